// File: rtl/core_dispatcher.sv
// Event dispatcher: pops events from a shared queue onto idle cores and
// returns finished core events to the queue, one transfer per two cycles.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   q_deq_vld/q_deq_data/q_deq_rdy   queue head and one-cycle pop strobe
//   q_enq_vld/q_enq_data/q_enq_rdy   event returned to the queue
//   core_idle                   per-core "can accept an event"
//   core_in_vld/core_in_data    one-hot dispatch strobe, shared data bus
//   core_out_vld/core_out_data  per-core returning event, packed by core
//   core_out_ack                one-hot pop strobe to the returning core
//   mon_*                       monitor feed of sent/received events
//   halt, all_idle              block dispatches; nothing outstanding
module core_dispatcher #(
  parameter int NUM_CORE = 4,
  parameter int MSG_WID  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          q_deq_vld,
  input  logic [MSG_WID-1:0]            q_deq_data,
  output logic                          q_deq_rdy,
  output logic                          q_enq_vld,
  output logic [MSG_WID-1:0]            q_enq_data,
  input  logic                          q_enq_rdy,
  input  logic [NUM_CORE-1:0]           core_idle,
  output logic [NUM_CORE-1:0]           core_in_vld,
  output logic [MSG_WID-1:0]            core_in_data,
  input  logic [NUM_CORE-1:0]           core_out_vld,
  input  logic [NUM_CORE*MSG_WID-1:0]   core_out_data,
  output logic [NUM_CORE-1:0]           core_out_ack,
  output logic                          mon_sent_vld,
  output logic                          mon_rcv_vld,
  output logic [$clog2(NUM_CORE)-1:0]   mon_core_id,
  output logic [MSG_WID-1:0]            mon_msg,
  input  logic                          halt,
  output logic                          all_idle
);

  localparam int ID_W  = $clog2(NUM_CORE);
  localparam int CNT_W = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RECV
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [NUM_CORE-1:0]  busy;
  logic [CNT_W-1:0]     active_cnt;
  logic [ID_W-1:0]      rr_snd;
  logic [ID_W-1:0]      rr_rcv;
  logic [ID_W-1:0]      id_q;
  logic [MSG_WID-1:0]   data_q;

  logic [NUM_CORE-1:0]  snd_req;
  logic [NUM_CORE-1:0]  id_oh;
  logic                 rcv_ok;
  logic                 snd_ok;
  logic [ID_W-1:0]      rcv_g;
  logic [ID_W-1:0]      snd_g;
  logic [MSG_WID-1:0]   rcv_data;

  // First requester at or above p; the index wraps because NUM_CORE
  // is a power of two.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [NUM_CORE-1:0] req,
    input logic [ID_W-1:0]     p
  );
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] r;
    logic            found;
    r     = p;
    found = 1'b0;
    for (int i = 0; i < NUM_CORE; i++) begin
      idx = p + ID_W'(i);
      if (!found && req[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    snd_req  = core_idle & ~busy;
    rcv_ok   = (|core_out_vld) & q_enq_rdy;
    snd_ok   = q_deq_vld & ~halt & (|snd_req);
    rcv_g    = rr_pick(core_out_vld, rr_rcv);
    snd_g    = rr_pick(snd_req, rr_snd);
    rcv_data = '0;
    for (int k = 0; k < NUM_CORE; k++) begin
      if (rcv_g == ID_W'(k)) begin
        rcv_data = core_out_data[k*MSG_WID +: MSG_WID];
      end
    end
  end

  assign id_oh        = {{(NUM_CORE-1){1'b0}}, 1'b1} << id_q;
  assign core_in_data = data_q;
  assign q_enq_data   = data_q;
  assign mon_core_id  = id_q;
  assign mon_msg      = data_q;
  assign all_idle     = (state == S_IDLE) && (active_cnt == '0);

  always_comb begin
    state_d      = state;
    q_deq_rdy    = 1'b0;
    q_enq_vld    = 1'b0;
    core_in_vld  = '0;
    core_out_ack = '0;
    mon_sent_vld = 1'b0;
    mon_rcv_vld  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rcv_ok) begin
          state_d = S_RECV;
        end else if (snd_ok) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        q_deq_rdy    = 1'b1;
        core_in_vld  = id_oh;
        mon_sent_vld = 1'b1;
        state_d      = S_IDLE;
      end
      S_RECV: begin
        q_enq_vld   = 1'b1;
        mon_rcv_vld = 1'b1;
        if (q_enq_rdy) begin
          core_out_ack = id_oh;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= '0;
      active_cnt <= '0;
      rr_snd     <= '0;
      rr_rcv     <= '0;
      id_q       <= '0;
      data_q     <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (rcv_ok) begin
            id_q   <= rcv_g;
            data_q <= rcv_data;
          end else if (snd_ok) begin
            id_q   <= snd_g;
            data_q <= q_deq_data;
          end
        end
        S_SEND: begin
          busy[id_q] <= 1'b1;
          if (!busy[id_q]) begin
            active_cnt <= active_cnt + CNT_W'(1);
          end
          rr_snd <= id_q + ID_W'(1);
        end
        S_RECV: begin
          if (q_enq_rdy) begin
            busy[id_q] <= 1'b0;
            // a return from a core we never loaded leaves the count alone
            if (busy[id_q]) begin
              active_cnt <= active_cnt - CNT_W'(1);
            end
            rr_rcv <= id_q + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_dispatcher.sv
// Self-checking bench for core_dispatcher: dispatch vector table plus
// hand-written return, stall, halt and reset sequences.
module tb_core_dispatcher;

  localparam int NC = 4;
  localparam int MW = 32;

  logic            clk;
  logic            reset;
  logic            q_deq_vld;
  logic [MW-1:0]   q_deq_data;
  logic            q_deq_rdy;
  logic            q_enq_vld;
  logic [MW-1:0]   q_enq_data;
  logic            q_enq_rdy;
  logic [NC-1:0]   core_idle;
  logic [NC-1:0]   core_in_vld;
  logic [MW-1:0]   core_in_data;
  logic [NC-1:0]   core_out_vld;
  logic [NC*MW-1:0] core_out_data;
  logic [NC-1:0]   core_out_ack;
  logic            mon_sent_vld;
  logic            mon_rcv_vld;
  logic [1:0]      mon_core_id;
  logic [MW-1:0]   mon_msg;
  logic            halt;
  logic            all_idle;

  core_dispatcher #(.NUM_CORE(NC), .MSG_WID(MW)) dut (
    .clk(clk),
    .reset(reset),
    .q_deq_vld(q_deq_vld),
    .q_deq_data(q_deq_data),
    .q_deq_rdy(q_deq_rdy),
    .q_enq_vld(q_enq_vld),
    .q_enq_data(q_enq_data),
    .q_enq_rdy(q_enq_rdy),
    .core_idle(core_idle),
    .core_in_vld(core_in_vld),
    .core_in_data(core_in_data),
    .core_out_vld(core_out_vld),
    .core_out_data(core_out_data),
    .core_out_ack(core_out_ack),
    .mon_sent_vld(mon_sent_vld),
    .mon_rcv_vld(mon_rcv_vld),
    .mon_core_id(mon_core_id),
    .mon_msg(mon_msg),
    .halt(halt),
    .all_idle(all_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rcv;
    logic [1:0]  core;
    logic [31:0] msg;
  } exp_t;

  typedef struct {
    logic [31:0] msg;
    logic [3:0]  idle;
    int          core;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  vec_t tbl[4];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic rcv, input int core, input logic [31:0] m);
    exp_t x;
    x.rcv  = rcv;
    x.core = 2'(core);
    x.msg  = m;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cores pop on ack, the queue empties after a pop; runs until the
  // scoreboard drains or the cycle budget expires.
  task automatic pump(input int budget, input string tag);
    logic [NC-1:0] ack;
    logic          pop;
    int            n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      ack = core_out_ack;
      pop = q_deq_rdy;
      @(posedge clk);
      #1;
      core_out_vld = core_out_vld & ~ack;
      if (pop) q_deq_vld = 1'b0;
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_out(input int k, input logic [31:0] m);
    core_out_data[k*MW +: MW] = m;
  endtask

  // Scoreboard: every transfer strobe must match the next expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (q_deq_rdy || mon_sent_vld || (|core_in_vld) || (|core_out_ack)
          || (mon_rcv_vld && q_enq_rdy)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected snd=%0b rcv=%0b id=%0d t=%0t",
                   mon_sent_vld, mon_rcv_vld, mon_core_id, $time);
        end else begin
          e = exp_q.pop_front();
          if (!e.rcv) begin
            check("snd_strobes",
                  {52'd0, q_deq_rdy, mon_sent_vld, core_in_vld,
                   mon_rcv_vld, q_enq_vld, core_out_ack},
                  {52'd0, 1'b1, 1'b1, 4'b0001 << e.core,
                   1'b0, 1'b0, 4'b0000});
            check("snd_data", 64'(core_in_data), 64'(e.msg));
          end else begin
            check("rcv_strobes",
                  {52'd0, q_deq_rdy, mon_sent_vld, core_in_vld,
                   mon_rcv_vld, q_enq_vld, core_out_ack},
                  {52'd0, 1'b0, 1'b0, 4'b0000,
                   1'b1, 1'b1, 4'b0001 << e.core});
            check("rcv_data", 64'(q_enq_data), 64'(e.msg));
          end
          check("mon_feed", {30'd0, mon_core_id, mon_msg},
                {30'd0, e.core, e.msg});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0001_0005, 4'b1111, 0};
    tbl[1] = '{32'h0001_00A1, 4'b0110, 1};
    tbl[2] = '{32'h0001_00A2, 4'b1100, 2};
    tbl[3] = '{32'h0001_00A3, 4'b1111, 3};

    reset         = 1'b1;
    q_deq_vld     = 1'b0;
    q_deq_data    = '0;
    q_enq_rdy     = 1'b1;
    core_idle     = '0;
    core_out_vld  = '0;
    core_out_data = '0;
    halt          = 1'b0;
    step();
    step();
    check("reset_outs",
          {50'd0, q_deq_rdy, q_enq_vld, mon_sent_vld, mon_rcv_vld,
           core_in_vld, core_out_ack, all_idle},
          {50'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1});
    reset = 1'b0;
    step();
    check("post_reset_idle", 64'(all_idle), 64'd1);

    // dispatch table with the queue held valid throughout
    q_deq_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_deq_data = tbl[i].msg;
      core_idle  = tbl[i].idle;
      push(1'b0, tbl[i].core, tbl[i].msg);
      step();
      check("send_all_idle", 64'(all_idle), 64'd0);
      step();
    end
    q_deq_data = 32'hDEAD_0005;
    core_idle  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("blocked_send", {62'd0, q_deq_rdy, |core_in_vld}, 64'd0);
    end
    check("cnt_full", 64'(dut.active_cnt), 64'd4);
    check("tbl_drain", 64'(exp_q.size()), 64'd0);
    q_deq_vld = 1'b0;

    // return held off by q_enq_rdy, then acked for one cycle
    set_out(2, 32'h0002_0002);
    core_out_vld = 4'b0100;
    q_enq_rdy    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("enq_blocked", {59'd0, mon_rcv_vld, core_out_ack}, 64'd0);
    end
    q_enq_rdy = 1'b1;
    push(1'b1, 2, 32'h0002_0002);
    pump(6, "ret2");
    check("ack_one_cycle", 64'(core_out_ack), 64'd0);

    // two returns beat a pending send; core 2 is no longer busy
    set_out(1, 32'h0000_00B1);
    set_out(2, 32'h0000_00B2);
    core_out_vld = 4'b0110;
    q_deq_vld    = 1'b1;
    q_deq_data   = 32'h0000_0055;
    push(1'b1, 1, 32'h0000_00B1);
    push(1'b1, 2, 32'h0000_00B2);
    push(1'b0, 1, 32'h0000_0055);
    pump(12, "rcv_prio");
    check("cnt_no_underflow", 64'(dut.active_cnt), 64'd3);

    // receive stalls inside the state while q_enq_rdy is low
    set_out(3, 32'h0000_00C3);
    core_out_vld = 4'b1000;
    push(1'b1, 3, 32'h0000_00C3);
    step();
    q_enq_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rcv_hold",
            {56'd0, q_enq_vld, mon_rcv_vld, mon_core_id, core_out_ack},
            {56'd0, 1'b1, 1'b1, 2'd3, 4'b0000});
      step();
    end
    q_enq_rdy = 1'b1;
    pump(5, "rcv_stall");

    // halt blocks sends but not returns
    halt         = 1'b1;
    q_deq_vld    = 1'b1;
    q_deq_data   = 32'h0000_0077;
    set_out(0, 32'h0000_00D0);
    set_out(1, 32'h0000_00D1);
    core_out_vld = 4'b0011;
    push(1'b1, 0, 32'h0000_00D0);
    push(1'b1, 1, 32'h0000_00D1);
    pump(10, "halt_rcv");
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_no_send", {62'd0, q_deq_rdy, |core_in_vld}, 64'd0);
    end
    check("halt_all_idle", 64'(all_idle), 64'd1);
    halt      = 1'b0;
    q_deq_vld = 1'b0;

    // reset while holding an un-acked return
    q_deq_vld  = 1'b1;
    q_deq_data = 32'h0000_0088;
    push(1'b0, 2, 32'h0000_0088);
    pump(5, "pre_rst_send");
    set_out(2, 32'h0000_00E2);
    core_out_vld = 4'b0100;
    step();
    q_enq_rdy = 1'b0;
    #1;
    check("rst_in_recv", {59'd0, mon_rcv_vld, core_out_ack},
          {59'd0, 1'b1, 4'b0000});
    reset = 1'b1;
    step();
    core_out_vld = '0;
    check("rst_outs",
          {50'd0, q_deq_rdy, q_enq_vld, mon_sent_vld, mon_rcv_vld,
           core_in_vld, core_out_ack, all_idle},
          {50'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1});
    check("rst_cnt", 64'(dut.active_cnt), 64'd0);
    reset     = 1'b0;
    q_enq_rdy = 1'b1;
    q_deq_vld = 1'b1;
    q_deq_data = 32'h0000_0099;
    push(1'b0, 0, 32'h0000_0099);
    pump(5, "post_rst_send");

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
